// File: rtl/axis_framer_pkg.sv
// Shared types and constants for the AXI-Stream framer and its skid buffer.
package axis_framer_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   localparam int DEFAULT_LEN_WIDTH = 16;
   localparam int STAT_WIDTH        = 32;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: all outputs registered, full throughput, ready never
// depends combinationally on out_ready.
module axis_skid_buffer
   import axis_framer_pkg::*;
#(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   skid_state_e      state_r;
   skid_state_e      state_nxt_s;
   logic [WIDTH-1:0] out_data_r;
   logic [WIDTH-1:0] out_data_nxt_s;
   logic [WIDTH-1:0] skid_data_r;
   logic [WIDTH-1:0] skid_data_nxt_s;
   logic             ready_r;
   logic             valid_r;
   logic             accept_s;
   logic             handshake_s;

   assign accept_s    = in_valid & ready_r;
   assign handshake_s = valid_r & out_ready;

   // Next-state and next-payload selection for the buffer occupancy.
   always_comb begin
      state_nxt_s     = state_r;
      out_data_nxt_s  = out_data_r;
      skid_data_nxt_s = skid_data_r;
      case (state_r)
         EMPTY: begin
            if (accept_s) begin
               state_nxt_s    = ONE;
               out_data_nxt_s = in_data;
            end else begin
               state_nxt_s = EMPTY;
            end
         end
         ONE: begin
            if (accept_s && handshake_s) begin
               state_nxt_s    = ONE;
               out_data_nxt_s = in_data;
            end else if (accept_s) begin
               state_nxt_s     = TWO;
               skid_data_nxt_s = in_data;
            end else if (handshake_s) begin
               state_nxt_s = EMPTY;
            end else begin
               state_nxt_s = ONE;
            end
         end
         TWO: begin
            // in_ready is low here, so only the drain path matters
            if (handshake_s) begin
               state_nxt_s    = ONE;
               out_data_nxt_s = skid_data_r;
            end else begin
               state_nxt_s = TWO;
            end
         end
         default: begin
            state_nxt_s = EMPTY;
         end
      endcase
   end

   // State, payload and registered handshake flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= EMPTY;
         out_data_r  <= {WIDTH{1'b0}};
         skid_data_r <= {WIDTH{1'b0}};
         ready_r     <= 1'b0;
         valid_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         out_data_r  <= out_data_nxt_s;
         skid_data_r <= skid_data_nxt_s;
         ready_r     <= (state_nxt_s != TWO);
         valid_r     <= (state_nxt_s != EMPTY);
      end
   end

   assign in_ready  = ready_r;
   assign out_data  = out_data_r;
   assign out_valid = valid_r;

endmodule

// File: rtl/axis_framer.sv
// AXI-Stream framer: tags tlast on every N-th accepted beat (N latched per
// frame) and counts frames completed downstream.
module axis_framer
   import axis_framer_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [STAT_WIDTH-1:0] stat_frame_count
);

   localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   logic [LEN_WIDTH-1:0]  beat_cnt_r;
   logic [LEN_WIDTH-1:0]  cur_len_r;
   logic [LEN_WIDTH-1:0]  len_s;
   logic [STAT_WIDTH-1:0] frame_cnt_r;
   logic                  accept_s;
   logic                  last_s;
   logic [DATA_WIDTH:0]   out_payload_s;

   assign accept_s = s_axis_tvalid & s_axis_tready;

   // First beat of a frame decides with the live config, later beats with the latch.
   always_comb begin
      len_s = cur_len_r;
      if (beat_cnt_r == LEN_ZERO) begin
         if (cfg_frame_len == LEN_ZERO) begin
            len_s = LEN_ONE;
         end else begin
            len_s = cfg_frame_len;
         end
      end else begin
         len_s = cur_len_r;
      end
   end

   assign last_s = (beat_cnt_r == (len_s - LEN_ONE));

   // Beat index and per-frame length latch, advanced only by accepted beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_r <= LEN_ZERO;
         cur_len_r  <= LEN_ONE;
      end else if (accept_s) begin
         if (beat_cnt_r == LEN_ZERO) begin
            cur_len_r <= len_s;
         end else begin
            cur_len_r <= cur_len_r;
         end
         if (last_s) begin
            beat_cnt_r <= LEN_ZERO;
         end else begin
            beat_cnt_r <= beat_cnt_r + LEN_ONE;
         end
      end else begin
         beat_cnt_r <= beat_cnt_r;
         cur_len_r  <= cur_len_r;
      end
   end

   // Frames are counted when their last beat is taken downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_r <= {STAT_WIDTH{1'b0}};
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         frame_cnt_r <= frame_cnt_r + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   axis_skid_buffer #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({last_s, s_axis_tdata}),
      .in_valid  (s_axis_tvalid),
      .in_ready  (s_axis_tready),
      .out_data  (out_payload_s),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

   assign m_axis_tdata     = out_payload_s[DATA_WIDTH-1:0];
   assign m_axis_tlast     = out_payload_s[DATA_WIDTH];
   assign stat_frame_count = frame_cnt_r;

endmodule

// File: tb/tb_axis_framer.sv
// Self-checking bench for axis_framer: queue-based reference model compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_axis_framer;

   localparam int DW = 64;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [LW-1:0] cfg = 16'd4;
   logic [DW-1:0] s_tdata = 64'd0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic          m_tlast;
   logic [31:0]   stat;

   always #5 clk = ~clk;

   axis_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_frame_len    (cfg),
      .s_axis_tdata     (s_tdata),
      .s_axis_tvalid    (s_tvalid),
      .s_axis_tready    (s_tready),
      .m_axis_tdata     (m_tdata),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tready    (m_tready),
      .m_axis_tlast     (m_tlast),
      .stat_frame_count (stat)
   );

   int nchecks = 0;
   int nerr    = 0;

   // Reference model state: beats accepted but not yet handed downstream.
   logic [DW:0] expq[$];
   logic [DW:0] outlog[$];
   int          m_rem = 0;
   int unsigned m_frames = 0;
   bit          m_rst_state = 1'b0;
   bit          armed = 1'b0;
   bit          prev_stall = 1'b0;
   logic [DW:0] prev_out = '0;
   int          bp_mode = 1;   // 0: stalled, 1: always ready, 2: random

   task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model, then apply the transfers of the coming edge.
   always @(negedge clk) begin
      logic [DW:0] item;
      if (armed) begin
         if (m_rst_state) begin
            check("rst_tready", {64'd0, s_tready}, 65'd0);
            check("rst_tvalid", {64'd0, m_tvalid}, 65'd0);
            check("rst_tdata",  {1'b0, m_tdata}, 65'd0);
            check("rst_tlast",  {64'd0, m_tlast}, 65'd0);
            check("rst_stat",   {33'd0, stat}, 65'd0);
         end else begin
            check("tready", {64'd0, s_tready}, {64'd0, (expq.size() < 2)});
            check("tvalid", {64'd0, m_tvalid}, {64'd0, (expq.size() > 0)});
            if (expq.size() > 0)
               check("payload", {m_tlast, m_tdata}, expq[0]);
            if (prev_stall)
               check("stall_hold", {m_tlast, m_tdata}, prev_out);
            check("frames", {33'd0, stat}, {33'd0, m_frames});
         end
      end
      if (rst) begin
         expq.delete();
         m_rem       = 0;
         m_frames    = 0;
         m_rst_state = 1'b1;
         prev_stall  = 1'b0;
         armed       = 1'b1;
      end else if (armed) begin
         prev_stall = m_tvalid && !m_tready;
         prev_out   = {m_tlast, m_tdata};
         if (m_tvalid && m_tready && expq.size() > 0) begin
            item = expq.pop_front();
            outlog.push_back({m_tlast, m_tdata});
            if (item[DW]) m_frames++;
         end
         if (s_tvalid && s_tready) begin
            if (m_rem == 0) m_rem = (cfg == 16'd0) ? 1 : int'(cfg);
            m_rem--;
            expq.push_back({(m_rem == 0), s_tdata});
         end
         m_rst_state = 1'b0;
      end
   end

   // Downstream ready pattern, updated just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (bp_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send(input int n, input logic [DW-1:0] first, input int gap_pct, input bit rnd);
      bit acc;
      int t;
      for (int i = 0; i < n; i++) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         s_tdata  = rnd ? {$urandom, $urandom} : first + DW'(i);
         s_tvalid = 1'b1;
         t = 0;
         do begin
            acc = s_tready;
            @(posedge clk);
            #1;
            t++;
         end while (!acc && t < 200);
         if (!acc) check("send_timeout", {64'd0, acc}, 65'd1);
      end
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((expq.size() > 0 || m_tvalid) && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain", {64'd0, (expq.size() == 0)}, 65'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = {$urandom, $urandom};
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      check("in_rst_tready", {64'd0, s_tready}, 65'd0);
      check("in_rst_tvalid", {64'd0, m_tvalid}, 65'd0);
      rst      = 1'b0;
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_tready", {64'd0, s_tready}, 65'd1);
      check("post_rst_tvalid", {64'd0, m_tvalid}, 65'd0);
      outlog.delete();
   endtask

   initial begin
      int lasts;

      // Fixed length 4, data 1..12
      bp_mode = 1;
      do_reset(3);
      cfg = 16'd4;
      send(1, 64'd1, 0, 1'b0);
      check("latency_valid", {64'd0, m_tvalid}, 65'd1);
      check("latency_data", {1'b0, m_tdata}, 65'd1);
      send(11, 64'd2, 0, 1'b0);
      drain();
      check("fixed_count", 65'(outlog.size()), 65'd12);
      for (int i = 0; i < outlog.size(); i++)
         check("fixed_beat", outlog[i], {((i % 4) == 3), 64'(i + 1)});
      check("fixed_stat", {33'd0, stat}, 65'd3);

      // Length change mid-frame: 3 then 2 -> lasts on 3, 5, 7
      do_reset(2);
      cfg = 16'd3;
      send(2, 64'd1, 0, 1'b0);
      cfg = 16'd2;
      send(5, 64'd3, 0, 1'b0);
      drain();
      check("chg_count", 65'(outlog.size()), 65'd7);
      for (int i = 0; i < outlog.size(); i++)
         check("chg_beat", outlog[i], {(i == 2 || i == 4 || i == 6), 64'(i + 1)});
      check("chg_stat", {33'd0, stat}, 65'd3);

      // Zero length behaves as one
      do_reset(2);
      cfg = 16'd0;
      send(5, 64'h50, 0, 1'b0);
      drain();
      check("zero_count", 65'(outlog.size()), 65'd5);
      for (int i = 0; i < outlog.size(); i++)
         check("zero_beat", outlog[i], {1'b1, 64'(64'h50 + i)});
      check("zero_stat", {33'd0, stat}, 65'd5);

      // Random backpressure, 1000 beats, len 7
      do_reset(2);
      cfg = 16'd7;
      bp_mode = 2;
      send(1000, 64'd0, 10, 1'b1);
      drain();
      bp_mode = 1;
      lasts = 0;
      for (int i = 0; i < outlog.size(); i++) begin
         if (outlog[i][DW]) lasts++;
         check("bp_last_pos", {64'd0, outlog[i][DW]}, {64'd0, ((i % 7) == 6)});
      end
      check("bp_count", 65'(outlog.size()), 65'd1000);
      check("bp_lasts", 65'(lasts), 65'd142);
      check("bp_stat", {33'd0, stat}, 65'd142);

      // Reset while holding two beats of a len-4 frame
      do_reset(2);
      cfg = 16'd4;
      bp_mode = 0;
      @(posedge clk);
      #1;
      send(2, 64'h100, 0, 1'b0);
      check("two_tready", {64'd0, s_tready}, 65'd0);
      check("two_tvalid", {64'd0, m_tvalid}, 65'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bp_mode = 1;
      outlog.delete();
      send(4, 64'h200, 0, 1'b0);
      drain();
      check("mid_count", 65'(outlog.size()), 65'd4);
      for (int i = 0; i < outlog.size(); i++)
         check("mid_beat", outlog[i], {(i == 3), 64'(64'h200 + i)});
      check("mid_stat", {33'd0, stat}, 65'd1);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule

// File: doc/axis_framer.md
# axis_framer

Downstream AXI-Stream stage that consumes the headerless stream from the one-beat delay stage and imposes framing: it marks `tlast` on every N-th accepted beat, where N is a runtime length latched per frame. A 2-entry skid buffer registers all outputs and keeps full throughput under backpressure. It also counts completed frames for status. It sits between the delay stage and any packet-oriented consumer.

## Interface

Parameters:
- `DATA_WIDTH`, 64, stream data width in bits.
- `LEN_WIDTH`, 16, width of the frame-length configuration.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `cfg_frame_len`  in  LEN_WIDTH  beats per frame. Sampled only at frame start. 0 is treated as 1.
- `s_axis_tdata`  in  DATA_WIDTH  input data.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready; registered.
- `m_axis_tdata`  out  DATA_WIDTH  output data; registered.
- `m_axis_tvalid`  out  1  output valid; registered.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tlast`  out  1  last beat of frame; registered.
- `stat_frame_count`  out  32  number of frames whose last beat was accepted downstream; wraps modulo 2^32.

## Operation

- **Input acceptance:** an input beat is accepted when `s_axis_tvalid & s_axis_tready`. Only accepted beats advance framing state.
- **Beat counter:** `beat_cnt` (LEN_WIDTH bits) indexes the accepted beat within the current frame, from 0 to len-1.
- **Length latch:** on acceptance with `beat_cnt==0`, the frame length is `max(cfg_frame_len,1)`, latched into `cur_len`.
  - That first beat's own tlast decision uses this value directly, not the stale `cur_len`.
  - `cfg_frame_len` changes mid-frame have no effect until the next frame.
- **tlast tagging:** an accepted beat is tagged `last=1` iff `beat_cnt == len-1`. On a tagged beat, `beat_cnt` returns to 0; otherwise it increments.
  - With len=1, every beat is tagged.
  - With len=2^LEN_WIDTH-1, the counter reaches 2^LEN_WIDTH-2 and never wraps uncontrolled.
- **Skid buffer:** `{last,tdata}` enter a 2-entry skid buffer. States:
  - EMPTY: no entry held; `m_axis_tvalid=0`.
  - ONE: output register valid.
  - TWO: output register and skid register both valid; `s_axis_tready=0`.
- **Transitions:**
  - EMPTY→ONE on accept.
  - ONE→EMPTY on output handshake without accept.
  - ONE→ONE on accept and handshake together, or on neither.
  - ONE→TWO on accept without handshake.
  - TWO→ONE on handshake; the skid register moves to the output register.
- **Ready:** `s_axis_tready` is registered. It is 1 in EMPTY and ONE, and 0 in TWO. It never depends combinationally on `m_axis_tready`.
- **Output hold:** output data/last are stable while `m_axis_tvalid & !m_axis_tready`.
- **Frame count:** `stat_frame_count` increments on an output handshake with `m_axis_tlast=1`.

## Timing

- **Reset values:** `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `s_axis_tready=0`, `stat_frame_count=0`; `beat_cnt=0`, `cur_len=1`, state EMPTY.
  - `s_axis_tready` rises on the first edge after `rst` deasserts.
- **Reset mid-frame:** discards both buffer entries and the partial frame. The next accepted beat starts a new frame.
- **Latency:** an accepted beat appears on `m_axis_*` at the next edge when the buffer was EMPTY, or when it was ONE and the output handshake occurred that cycle.
- **Throughput:** 1 beat/cycle sustained while `m_axis_tready=1`.
- **Backpressure:** at most 2 beats are absorbed after `m_axis_tready` falls. No beat is ever dropped or duplicated.
- **Simultaneous accept and output handshake in ONE:** the new beat replaces the output register at the same edge.

## Structure

- Package `axis_framer_pkg`: skid state enum (`EMPTY`, `ONE`, `TWO`), default `LEN_WIDTH`, and the `stat_frame_count` width constant (32).
- Sub-module `axis_skid_buffer`, parameterised on payload width, instantiated with width `DATA_WIDTH+1` to carry `{last,tdata}`.
- The top level holds the beat counter, length latch and frame counter.

## Test plan

- **Reset:** hold `rst` 3 cycles with `s_axis_tvalid=1` → all outputs at reset values, `s_axis_tready=0` during reset, 1 one cycle after, nothing accepted during reset.
- **Fixed length:** `cfg_frame_len=4`, stream data 1..12 with `m_axis_tready=1` → output 1..12, 1 cycle latency, `tlast` on 4, 8, 12, `stat_frame_count=3`.
- **Length change mid-frame:** `cfg_frame_len=3`, change to 2 after beat 2 → `tlast` on beats 3, 5, 7.
- **Zero length:** `cfg_frame_len=0`, 5 beats → `tlast` on every beat, `stat_frame_count=5`.
- **Backpressure:** random `m_axis_tready` (50%) over 1000 beats, len=7 → in-order, lossless output. `s_axis_tready` drops only in TWO. Data/last stay stable while stalled. `stat_frame_count=142`.
- **Reset mid-frame:** pulse `rst` with the buffer in TWO and `beat_cnt=2` (len=4) → both entries discarded. The next 4 beats form one frame with `tlast` on the 4th.
